// File: rtl/id_decode_buffer_if.sv
// Fetch-to-execute handshake bundle for the decode buffer. The slave modport is the
// decode stage; out_illegal exists only when ID_ILLEGAL_TRAP_EN is defined.
interface id_decode_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc;
  logic [DATA_W-1:0] in_instr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [5:0]        out_opcode;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;
  logic [4:0]        out_rd;
  logic [4:0]        out_shamt;
  logic [5:0]        out_funct;
  logic [31:0]       out_imm;
  logic [ADDR_W-1:0] out_target;
  logic              out_is_branch;
  logic              out_is_jump;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
`ifdef ID_ILLEGAL_TRAP_EN
  logic              out_illegal;
`endif

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
`ifdef ID_ILLEGAL_TRAP_EN
    output out_illegal,
`endif
    output in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
           out_shamt, out_funct, out_imm, out_target, out_is_branch, out_is_jump,
           out_reg_write, out_mem_read, out_mem_write
  );

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
`ifdef ID_ILLEGAL_TRAP_EN
    input  out_illegal,
`endif
    input  in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
           out_shamt, out_funct, out_imm, out_target, out_is_branch, out_is_jump,
           out_reg_write, out_mem_read, out_mem_write
  );
endinterface

// File: rtl/id_decode_buffer.sv
// Instruction decode stage with a 2-entry skid FIFO of decoded bundles.
// Optional ID_ILLEGAL_TRAP_EN adds out_illegal for unknown opcodes / R-type functs.
module id_decode_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  id_decode_buffer_if.slave bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [31:0]       imm;
    logic [ADDR_W-1:0] target;
    logic              is_branch;
    logic              is_jump;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
`ifdef ID_ILLEGAL_TRAP_EN
    logic              illegal;
`endif
  } dec_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  dec_t              mem_q [2];
  dec_t              dec_d;
  dec_t              head;
  logic              push, pop, wr_en;
  logic [5:0]        opc;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] imm_a;

  assign bus.in_ready  = (state_q != TWO);
  assign bus.out_valid = (state_q != EMPTY);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // Decode is purely combinational on the fetch bundle; only the FIFO write registers it.
  assign opc      = bus.in_instr[31:26];
  assign pc_plus1 = bus.in_pc + ADDR_W'(1);
  assign imm_a    = {{(ADDR_W-16){bus.in_instr[15]}}, bus.in_instr[15:0]};

  always_comb begin
    dec_d        = '0;
    dec_d.pc     = bus.in_pc;
    dec_d.instr  = bus.in_instr;
    dec_d.imm    = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
    dec_d.target = pc_plus1;
    unique case (opc)
      6'h00: begin
        dec_d.reg_write = 1'b1;
`ifdef ID_ILLEGAL_TRAP_EN
        unique case (bus.in_instr[5:0])
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00: dec_d.illegal = 1'b0;
          default:                                  dec_d.illegal = 1'b1;
        endcase
`endif
      end
      6'h02: begin
        dec_d.is_jump = 1'b1;
        dec_d.target  = {pc_plus1[ADDR_W-1:26], bus.in_instr[25:0]};
      end
      6'h04, 6'h05: begin
        dec_d.is_branch = 1'b1;
        dec_d.target    = pc_plus1 + imm_a;
      end
      6'h08: dec_d.reg_write = 1'b1;
      6'h23: begin
        dec_d.reg_write = 1'b1;
        dec_d.mem_read  = 1'b1;
      end
      6'h2B: dec_d.mem_write = 1'b1;
      default: begin
`ifdef ID_ILLEGAL_TRAP_EN
        dec_d.illegal = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_en    = 1'b0;
    if (bus.flush) begin
      state_d  = EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      wr_en = push;
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      unique case (state_q)
        EMPTY:   if (push) state_d = ONE;
        ONE:     if (push && !pop) state_d = TWO;
                 else if (pop && !push) state_d = EMPTY;
        TWO:     if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Data regs are cleared only by reset so outputs read zero afterwards; flush keeps them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (wr_en) mem_q[wr_ptr_q] <= dec_d;
    end
  end

  assign head              = mem_q[rd_ptr_q];
  assign bus.out_pc        = head.pc;
  assign bus.out_opcode    = head.instr[31:26];
  assign bus.out_rs        = head.instr[25:21];
  assign bus.out_rt        = head.instr[20:16];
  assign bus.out_rd        = head.instr[15:11];
  assign bus.out_shamt     = head.instr[10:6];
  assign bus.out_funct     = head.instr[5:0];
  assign bus.out_imm       = head.imm;
  assign bus.out_target    = head.target;
  assign bus.out_is_branch = head.is_branch;
  assign bus.out_is_jump   = head.is_jump;
  assign bus.out_reg_write = head.reg_write;
  assign bus.out_mem_read  = head.mem_read;
  assign bus.out_mem_write = head.mem_write;
`ifdef ID_ILLEGAL_TRAP_EN
  assign bus.out_illegal   = head.illegal;
`endif

endmodule

// File: doc/id_decode_buffer.md
Name: id_decode_buffer

Overview:
- Instruction-decode stage directly downstream of instruction fetch.
- Accepts {pc, instruction word} from fetch over a valid/ready handshake and decodes it into register indices, a sign-extended immediate, control flags and a resolved branch/jump target.
- Holds decoded results in a 2-entry skid FIFO, so fetch can run one instruction ahead of an execute stage that stalls.
- A flush input from branch resolution discards all buffered instructions.

Parameters:
- ADDR_W, 32, PC width in bits; PC is word-addressed, sequential PC = pc + 1.
- DATA_W, 32, instruction word width; must be 32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  buffer can accept; equals (count != 2), combinational from state only.
- in_pc  in  ADDR_W  address of in_instr.
- in_instr  in  DATA_W  instruction word.
- flush  in  1  discard all buffered entries (taken branch/jump).
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes head.
- out_pc  out  ADDR_W  PC of head entry.
- out_opcode  out  6  instr[31:26].
- out_rs  out  5  instr[25:21].
- out_rt  out  5  instr[20:16].
- out_rd  out  5  instr[15:11].
- out_shamt  out  5  instr[10:6].
- out_funct  out  6  instr[5:0].
- out_imm  out  32  sign-extended instr[15:0].
- out_target  out  ADDR_W  branch/jump target.
- out_is_branch  out  1  opcode 0x04 (beq) or 0x05 (bne).
- out_is_jump  out  1  opcode 0x02 (j).
- out_reg_write  out  1  R-type (0x00), addi (0x08), lw (0x23).
- out_mem_read  out  1  lw.
- out_mem_write  out  1  sw (0x2B).

Behaviour:
- Decode is combinational on in_instr/in_pc; the decoded bundle is written into the FIFO on accept (in_valid & in_ready). Outputs are driven directly from the head entry registers.
- Latency: an instruction accepted at edge N is visible on out_* with out_valid = 1 after edge N; there is no combinational path from in_* to out_*.
- State is count ∈ {EMPTY = 0, ONE = 1, TWO = 2}, with 1-bit wr_ptr and rd_ptr.
- Transitions:
  - push only: count + 1.
  - pop only (out_valid & out_ready): count − 1.
  - push and pop together in ONE: count stays ONE; the new entry becomes head next cycle.
- Push while TWO cannot occur because in_ready = 0. Pop while EMPTY is ignored.
- out_target:
  - branch: (in_pc + 1 + out_imm) mod 2^ADDR_W; wraps silently.
  - jump: {pc_plus1[31:26], instr[25:0]}.
  - otherwise: pc + 1.
- Unknown opcodes decode with all control flags 0 and pass through as NOPs.
- flush (priority over everything except reset):
  - next cycle count = 0, pointers = 0, out_valid = 0.
  - any push in the same cycle is dropped.
  - any pop in the same cycle is irrelevant.
  - data registers keep their contents; only valid matters.
- reset:
  - count = 0, pointers = 0, out_valid = 0.
  - all out_* data outputs = 0.
  - in_ready = 1 from the first cycle after reset.
  - reset mid-operation behaves identically, discarding entries.
- out_* data fields are don't-care while out_valid = 0, except after reset, where they are 0.

Optional Feature:
- Macro: ID_ILLEGAL_TRAP_EN.
- Defined:
  - adds output out_illegal (1 bit), high when the head opcode is not in {0x00, 0x02, 0x04, 0x05, 0x08, 0x23, 0x2B}, or when opcode 0x00 has funct not in {0x20, 0x22, 0x24, 0x25, 0x2A, 0x00}.
  - out_illegal resets to 0.
  - an illegal entry is not popped until out_ready is seen, like any other entry.
- Undefined: the port is absent and unknown opcodes are silent NOPs.

Test Plan:
- Reset, then in_valid = 0 → out_valid = 0, in_ready = 1, all out_* = 0.
- Push pc = 0x10, instr = 0x20A5FFFF (addi r5, r5, −1) with out_ready = 1 → next cycle out_valid = 1, out_rs = 5, out_rt = 5, out_imm = 0xFFFFFFFF, out_reg_write = 1, out_target = 0x11.
- Push beq pc = 0x20, imm = 0xFFFC → out_is_branch = 1, out_target = 0x1D. Push beq pc = 0xFFFFFFFF, imm = 0 → out_target = 0x00000000 (wrap).
- out_ready = 0, push three instructions back-to-back → first two accepted, in_ready = 0 on the third. Raise out_ready → entries emerge in order and in_ready returns to 1 after the first pop.
- Buffer at TWO, assert flush together with in_valid = 1 → next cycle out_valid = 0, count = 0, the incoming instruction does not appear later.
- With ID_ILLEGAL_TRAP_EN: push opcode 0x3F → out_illegal = 1, all control flags 0. Push 0x00 with funct 0x20 → out_illegal = 0.
